// File: rtl/pipe_pkg.sv
// Shared types for the 5-stage pipeline control logic: forwarding selects,
// ResultSrc encodings and the hazard unit memory-wait state machine states.
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  // Must stay aligned with the ResultSrc mux in the datapath
  localparam logic [1:0] RES_ALU   = 2'b00;
  localparam logic [1:0] RES_MEM   = 2'b01;
  localparam logic [1:0] RES_PC4   = 2'b10;
  localparam logic [1:0] RES_PCIMM = 2'b11;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    MWAIT = 2'b01,
    ERR   = 2'b10
  } hazard_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + ONE;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard/forwarding controller for the F/D/E/M/W pipeline, with a data-memory
// wait-state FSM (ready handshake + timeout) and saturating stall/flush counters.
module pipeline_hazard_unit
  import pipe_pkg::*;
#(
  parameter int WAD         = 5,
  parameter int CW          = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [WAD-1:0] rs1_d,
  input  logic [WAD-1:0] rs2_d,
  input  logic [WAD-1:0] rs1_e,
  input  logic [WAD-1:0] rs2_e,
  input  logic [WAD-1:0] rd_e,
  input  logic [1:0]     result_src_e,
  input  logic [WAD-1:0] rd_m,
  input  logic           reg_write_m,
  input  logic [WAD-1:0] rd_w,
  input  logic           reg_write_w,
  input  logic           pc_src_e,
  input  logic           mem_req_m,
  input  logic           mem_ready,
  output logic [1:0]     fwd_a_e,
  output logic [1:0]     fwd_b_e,
  output logic           stall_f,
  output logic           stall_d,
  output logic           stall_e,
  output logic           stall_m,
  output logic           flush_d,
  output logic           flush_e,
  output logic           flush_w,
  output logic           mem_err,
  output logic [CW-1:0]  stall_cnt,
  output logic [CW-1:0]  flush_cnt
);

  localparam int            TW   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(MEM_TIMEOUT);
  localparam logic [TW-1:0] TONE = TW'(1);

  hazard_state_t r_state, w_state_nxt;
  logic [TW-1:0] r_tcnt, w_tcnt_nxt;
  logic          r_mem_err, w_mem_err_nxt;

  logic w_mem_hold;
  logic w_lu;
  logic w_redirect;

  // M-stage result is newer than W, so it wins; x0 is hardwired and never forwarded
  function automatic fwd_sel_t fwd_pick(
    input logic [WAD-1:0] rs,
    input logic [WAD-1:0] rdm,
    input logic           rwm,
    input logic [WAD-1:0] rdw,
    input logic           rww
  );
    if (rwm && (rdm == rs) && (rdm != '0)) begin
      return FWD_M;
    end else if (rww && (rdw == rs) && (rdw != '0)) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

  assign fwd_a_e = fwd_pick(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
  assign fwd_b_e = fwd_pick(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RUN;
      r_tcnt    <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_mem_err <= w_mem_err_nxt;
    end
  end

  // tcnt counts wait cycles already spent; the first miss in RUN is cycle 1
  always_comb begin
    w_state_nxt   = r_state;
    w_tcnt_nxt    = r_tcnt;
    w_mem_err_nxt = r_mem_err;
    case (r_state)
      RUN: begin
        if (mem_req_m && !mem_ready) begin
          w_state_nxt = MWAIT;
          w_tcnt_nxt  = TONE;
        end
      end
      MWAIT: begin
        if (mem_ready) begin
          w_state_nxt = RUN;
          w_tcnt_nxt  = '0;
        end else if (r_tcnt == TMAX) begin
          w_state_nxt   = ERR;
          w_mem_err_nxt = 1'b1;
        end else begin
          w_tcnt_nxt = r_tcnt + TONE;
        end
      end
      ERR: begin
        w_state_nxt = ERR;
      end
      default: begin
        w_state_nxt = RUN;
        w_tcnt_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    w_mem_hold = 1'b0;
    w_lu       = 1'b0;
    w_redirect = 1'b0;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    stall_m    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    flush_w    = 1'b0;

    w_mem_hold = ((r_state == MWAIT) && !mem_ready) ||
                 ((r_state == RUN) && mem_req_m && !mem_ready) ||
                 (r_state == ERR);

    if (w_mem_hold) begin
      // Freeze everything; a redirect sitting in E simply waits for release
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else begin
      w_lu = (result_src_e == RES_MEM) && (rd_e != '0) &&
             ((rd_e == rs1_d) || (rd_e == rs2_d));
      w_redirect = pc_src_e;
      stall_f = w_lu && !w_redirect;
      stall_d = w_lu && !w_redirect;
      flush_d = w_redirect;
      flush_e = w_redirect || w_lu;
    end
  end

  assign mem_err = r_mem_err;

  sat_counter #(.CW(CW)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_f),
    .count (stall_cnt)
  );

  sat_counter #(.CW(CW)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_redirect),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed scoreboard bench for pipeline_hazard_unit (CW=4, MEM_TIMEOUT=4).
module tb_pipeline_hazard_unit;
  import pipe_pkg::*;

  localparam int WAD = 5;
  localparam int CW  = 4;
  localparam int MT  = 4;

  // ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
  localparam logic [6:0] C_IDLE  = 7'b0000000;
  localparam logic [6:0] C_LU    = 7'b1100010;
  localparam logic [6:0] C_FLUSH = 7'b0000110;
  localparam logic [6:0] C_HOLD  = 7'b1111001;

  logic           clk = 1'b0;
  logic           rst;
  logic [WAD-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0]     result_src_e;
  logic           reg_write_m, reg_write_w, pc_src_e, mem_req_m, mem_ready;
  logic [1:0]     fwd_a_e, fwd_b_e;
  logic           stall_f, stall_d, stall_e, stall_m;
  logic           flush_d, flush_e, flush_w, mem_err;
  logic [CW-1:0]  stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_unit #(.WAD(WAD), .CW(CW), .MEM_TIMEOUT(MT)) dut (
    .clk          (clk),
    .rst          (rst),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .rs1_e        (rs1_e),
    .rs2_e        (rs2_e),
    .rd_e         (rd_e),
    .result_src_e (result_src_e),
    .rd_m         (rd_m),
    .reg_write_m  (reg_write_m),
    .rd_w         (rd_w),
    .reg_write_w  (reg_write_w),
    .pc_src_e     (pc_src_e),
    .mem_req_m    (mem_req_m),
    .mem_ready    (mem_ready),
    .fwd_a_e      (fwd_a_e),
    .fwd_b_e      (fwd_b_e),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .stall_e      (stall_e),
    .stall_m      (stall_m),
    .flush_d      (flush_d),
    .flush_e      (flush_e),
    .flush_w      (flush_w),
    .mem_err      (mem_err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  typedef struct packed {
    logic [1:0]    fa;
    logic [1:0]    fb;
    logic [6:0]    ctl;
    logic          err;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t          scoreQ[$];
  int            compared   = 0;
  int            mismatched = 0;
  logic [CW-1:0] modelStall;
  logic [CW-1:0] modelFlush;

  task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] fa, input logic [1:0] fb,
                               input logic [6:0] ctl, input logic err);
    exp_t e;
    e.fa  = fa;
    e.fb  = fb;
    e.ctl = ctl;
    e.err = err;
    e.sc  = modelStall;
    e.fc  = modelFlush;
    scoreQ.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (scoreQ.size() == 0) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL %s scoreboard empty observed=0 expected=1", tag);
      return;
    end
    e = scoreQ.pop_front();
    checkField({tag, ".fwd_a"}, 32'(fwd_a_e), 32'(e.fa));
    checkField({tag, ".fwd_b"}, 32'(fwd_b_e), 32'(e.fb));
    checkField({tag, ".ctl"},
               32'({stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}),
               32'(e.ctl));
    checkField({tag, ".mem_err"}, 32'(mem_err), 32'(e.err));
    checkField({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(e.sc));
    checkField({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(e.fc));
  endtask

  // One clock of stimulus: inputs already driven, expectation queued, checked at negedge
  task automatic cycle(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [6:0] ctl, input logic err);
    applyStimulus(fa, fb, ctl, err);
    @(negedge clk);
    checkOutput(tag);
    if (ctl[6] && (modelStall != '1)) modelStall++;
    if (ctl[2] && (modelFlush != '1)) modelFlush++;
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    rs1_d        = '0;
    rs2_d        = '0;
    rs1_e        = '0;
    rs2_e        = '0;
    rd_e         = '0;
    rd_m         = '0;
    rd_w         = '0;
    result_src_e = RES_ALU;
    reg_write_m  = 1'b0;
    reg_write_w  = 1'b0;
    pc_src_e     = 1'b0;
    mem_req_m    = 1'b0;
    mem_ready    = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    setIdle();
    modelStall = '0;
    modelFlush = '0;
    #2;
    applyStimulus(FWD_RF, FWD_RF, C_IDLE, 1'b0);
    checkOutput("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Forwarding priority and x0
    rs1_e = 5; rs2_e = 5; rd_m = 5; rd_w = 5; reg_write_m = 1'b1; reg_write_w = 1'b1;
    cycle("fwd_m_prio", FWD_M, FWD_M, C_IDLE, 1'b0);
    reg_write_m = 1'b0;
    cycle("fwd_w", FWD_W, FWD_W, C_IDLE, 1'b0);
    rs1_e = 0; rs2_e = 0; rd_m = 0; rd_w = 0; reg_write_m = 1'b1;
    cycle("fwd_x0", FWD_RF, FWD_RF, C_IDLE, 1'b0);
    rs1_e = 7; rd_m = 7; rs2_e = 9; rd_w = 9;
    cycle("fwd_mixed", FWD_M, FWD_W, C_IDLE, 1'b0);
    setIdle();

    // Load-use
    result_src_e = RES_MEM; rd_e = 3; rs2_d = 3;
    cycle("loaduse", FWD_RF, FWD_RF, C_LU, 1'b0);
    setIdle();
    cycle("loaduse_off", FWD_RF, FWD_RF, C_IDLE, 1'b0);
    result_src_e = RES_ALU; rd_e = 3; rs1_d = 3;
    cycle("alu_no_lu", FWD_RF, FWD_RF, C_IDLE, 1'b0);
    result_src_e = RES_MEM; rd_e = 0; rs1_d = 0;
    cycle("lu_x0", FWD_RF, FWD_RF, C_IDLE, 1'b0);

    // Branch together with load-use: flush wins
    result_src_e = RES_MEM; rd_e = 3; rs1_d = 3; pc_src_e = 1'b1;
    cycle("branch_lu", FWD_RF, FWD_RF, C_FLUSH, 1'b0);
    setIdle();
    cycle("branch_after", FWD_RF, FWD_RF, C_IDLE, 1'b0);

    // Three wait cycles with a deferred redirect and a suppressed load-use
    mem_req_m = 1'b1; mem_ready = 1'b0; pc_src_e = 1'b1;
    result_src_e = RES_MEM; rd_e = 4; rs1_d = 4;
    repeat (3) cycle("memwait", FWD_RF, FWD_RF, C_HOLD, 1'b0);
    mem_ready = 1'b1;
    cycle("mem_release", FWD_RF, FWD_RF, C_FLUSH, 1'b0);
    setIdle();
    cycle("after_wait", FWD_RF, FWD_RF, C_IDLE, 1'b0);

    // Stall counter saturation
    result_src_e = RES_MEM; rd_e = 6; rs2_d = 6;
    repeat (20) cycle("sat", FWD_RF, FWD_RF, C_LU, 1'b0);
    setIdle();
    cycle("sat_done", FWD_RF, FWD_RF, C_IDLE, 1'b0);

    // Asynchronous reset clears counters between edges
    rst = 1'b1;
    modelStall = '0;
    modelFlush = '0;
    #2;
    applyStimulus(FWD_RF, FWD_RF, C_IDLE, 1'b0);
    checkOutput("reset_mid");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Timeout into ERR
    mem_req_m = 1'b1; mem_ready = 1'b0;
    repeat (5) cycle("timeout_wait", FWD_RF, FWD_RF, C_HOLD, 1'b0);
    mem_req_m = 1'b0; mem_ready = 1'b1; pc_src_e = 1'b1;
    repeat (2) cycle("err_hold", FWD_RF, FWD_RF, C_HOLD, 1'b1);

    // Asynchronous reset out of ERR
    setIdle();
    rst = 1'b1;
    modelStall = '0;
    modelFlush = '0;
    #2;
    applyStimulus(FWD_RF, FWD_RF, C_IDLE, 1'b0);
    checkOutput("reset_err");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle("post_reset", FWD_RF, FWD_RF, C_IDLE, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
